mult5_seq_colsum: RTL and testbench

- Sequential 5x5 unsigned multiplier that resolves the product one column per clock.
- Each cycle it forms the partial-product bits of one column and adds the carry left over from the previous column, using a 2+2+1 style column counter.
- It emits one product bit per cycle, so a full product takes 2N column cycles.
- It is the consumer stage for the column-counter adders in the Multiply5bits datapath, and presents a start/done handshake to the surrounding control.

---
 rtl/mult5_pkg.sv | 27 ++
 rtl/mult_col_sum.sv | 22 ++
 rtl/mult5_seq_colsum.sv | 86 ++++++++
 tb/tb_mult5_seq_colsum.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mult5_pkg.sv
// Shared types and helpers for the column-serial 5x5 multiplier.
// col_bits works on MAX_N-wide vectors so one function serves every supported N.
package mult5_pkg;
  localparam int N_DEF  = 5;
  localparam int PW_DEF = 2 * N_DEF;
  localparam int CW_DEF = $clog2(PW_DEF) + 1;
  localparam int MAX_N  = 8;
  localparam int IW     = $clog2(MAX_N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Partial-product bits of column k: bit i holds a[i] & b[k-i] when in range.
  function automatic logic [MAX_N-1:0] col_bits(input logic [MAX_N-1:0] a,
                                                input logic [MAX_N-1:0] b,
                                                input int k, input int n);
    logic [MAX_N-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_N; i++)
      if (i < n && k - i >= 0 && k - i < n)
        c[IW'(i)] = a[IW'(i)] & b[IW'(k - i)];
    return c;
  endfunction
endpackage

// File: rtl/mult_col_sum.sv
// Column counter: popcount of the column bits plus the carry from the
// previous column; low bit is the product bit, the rest carries forward.
module mult_col_sum #(
  parameter int N  = 5,
  parameter int CW = 5
) (
  input  logic [N-1:0]  bits,
  input  logic [CW-1:0] carry_in,
  output logic          sum_bit,
  output logic [CW-1:0] carry_out
);
  logic [CW-1:0] s;

  // For N=5 this collapses to two 2-bit pair sums plus a single bit, plus carry.
  always_comb begin
    s = carry_in;
    for (int i = 0; i < N; i++)
      s = s + CW'(bits[i]);
    sum_bit   = s[0];
    carry_out = s >> 1;
  end
endmodule

// File: rtl/mult5_seq_colsum.sv
// Sequential unsigned multiplier resolving one product column per clock,
// LSB first, with a start/busy/done handshake and fixed 2N-cycle latency.
module mult5_seq_colsum
  import mult5_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int PW = 2 * N;
  localparam int CW = $clog2(PW) + 1;

  state_t        state, state_nx;
  logic [N-1:0]  a_r, b_r;
  logic [N-1:0]  cb;
  logic [CW-1:0] carry_r, carry_nx, col;
  logic [PW-1:0] sh;
  logic          sum_bit, last_col;

  assign cb       = N'(col_bits(MAX_N'(a_r), MAX_N'(b_r), int'(col), N));
  assign last_col = (col == CW'(PW - 1));

  mult_col_sum #(.N(N), .CW(CW)) u_col (
    .bits      (cb),
    .carry_in  (carry_r),
    .sum_bit   (sum_bit),
    .carry_out (carry_nx)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_col) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Product register only loads on entry to DONE, so partial sums never leak out.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= '0;
      col     <= '0;
      sh      <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_r     <= a;
          b_r     <= b;
          carry_r <= '0;
          col     <= '0;
          sh      <= '0;
        end
        RUN: begin
          carry_r <= carry_nx;
          col     <= col + CW'(1);
          sh      <= {sum_bit, sh[PW-1:1]};
          if (last_col) product <= {sum_bit, sh[PW-1:1]};
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mult5_seq_colsum.sv
// Directed + exhaustive bench for mult5_seq_colsum with a product scoreboard.
module tb_mult5_seq_colsum;
  localparam int N  = 5;
  localparam int PW = 2 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  a = '0, b = '0;
  logic          busy, done;
  logic [PW-1:0] product;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  logic [PW-1:0] exp_q[$];

  mult5_seq_colsum #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic pop_check(input string tag);
    logic [PW-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_product"}, 32'(product), 32'(e));
    end
  endtask

  // One operation from IDLE; optional operand scrambling and stray start pulses.
  task automatic do_op(input int ai, input int bi, input bit scramble, input bit stray);
    int lat, busy_cnt;
    bit seen;
    a = N'(ai); b = N'(bi); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(PW'(ai * bi));
    busy_cnt = busy ? 1 : 0;
    lat = 0; seen = 0;
    for (int c = 1; c <= 40; c++) begin
      if (scramble) begin a = N'($urandom); b = N'($urandom); end
      start = (stray && c == 4);
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      if (done) begin seen = 1; break; end
      if (busy) busy_cnt++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(PW));
    chk("busy_cycles", 32'(busy_cnt), 32'(PW));
    chk("busy_in_done", 32'(busy), 32'd0);
    pop_check("op");
    chk("final_carry", 32'(dut.carry_r), 32'd0);
    if (stray) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("stray_idle_busy", 32'(busy), 32'd0);
      chk("stray_no_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      chk("stray_not_run", 32'(busy), 32'd0);
    end else begin
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int last_done, bound;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    do_op(31, 31, 0, 0);
    do_op(0, 27, 0, 0);
    do_op(1, 17, 0, 0);
    do_op(21, 10, 1, 0);
    do_op(5, 6, 0, 1);
    chk("stray_product_hold", 32'(product), 32'd30);

    // Start held high: back-to-back operations every PW+2 cycles.
    start = 1'b1;
    last_done = 0;
    for (int op = 0; op < 3; op++) begin
      a = N'(7 + op * 9); b = N'(30 - op * 5);
      exp_q.push_back(PW'((7 + op * 9) * (30 - op * 5)));
      bound = 0;
      do begin @(posedge clk); #1; bound++; end while (!done && bound < 40);
      chk("b2b_done_seen", 32'(done), 32'd1);
      pop_check("b2b");
      if (op > 0) chk("b2b_period", 32'(cyc - last_done), 32'(PW + 2));
      last_done = cyc;
      if (op == 2) start = 1'b0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_stopped", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a run.
    a = N'(31); b = N'(29); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_product", 32'(product), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    do_op(31, 29, 0, 0);

    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        do_op(i, j, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
